// File: rtl/mem_preload_pkg.sv
// ---------------------------------------------------------------------------
// mem_preload_pkg
// Shared definitions for the memory preload engine:
//   - state_t     : FSM state encoding
//   - LANE_W      : byte-lane index width for the default 4-byte word
//   - lane_width  : lane index width for any supported word size
//   - range_err   : true when an image would run past the top of memory
// ---------------------------------------------------------------------------
package mem_preload_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam int DEF_WORD_BYTES = 4;

  // Lane index width; a 1-bit minimum keeps vector declarations legal.
  function automatic int lane_width(input int word_bytes);
    return (word_bytes > 1) ? $clog2(word_bytes) : 1;
  endfunction

  localparam int LANE_W = lane_width(DEF_WORD_BYTES);

  // base + cnt is evaluated in 64 bits, wide enough for any
  // ADDR_W + CNT_W + 1 this block is built with, so the sum never wraps.
  // An image ending exactly at 2**addr_w is legal.
  function automatic logic range_err(input logic [63:0] base,
                                     input logic [63:0] cnt,
                                     input int          addr_w);
    logic [63:0] limit;
    limit = 64'd1 << addr_w;
    return (base + cnt) > limit;
  endfunction

endpackage

// File: rtl/preload_word_packer.sv
// ---------------------------------------------------------------------------
// preload_word_packer
// Assembles incoming bytes into one memory word. Tracks the current lane,
// accumulates byte enables and places each byte in its lane. Lanes never
// written stay zero with their enable clear.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : start a new image; lane <= load_lane, word cleared
//   load_lane   : starting lane (low bits of the base address)
//   clear       : start the next word at lane 0, word cleared
//   accept      : a byte is taken this cycle
//   data        : byte to place in the current lane
//   be          : accumulated byte enables
//   wdata       : assembled word, lane i at bits [8*i+7:8*i]
//   last_lane   : current lane is the top lane of the word
// ---------------------------------------------------------------------------
module preload_word_packer #(
  parameter int WORD_BYTES = 4,
  parameter int LANE_BITS  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [LANE_BITS-1:0]      load_lane,
  input  logic                      clear,
  input  logic                      accept,
  input  logic [7:0]                data,
  output logic [WORD_BYTES-1:0]     be,
  output logic [8*WORD_BYTES-1:0]   wdata,
  output logic                      last_lane
);

  logic [LANE_BITS-1:0] lane;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane  <= '0;
      be    <= '0;
      wdata <= '0;
    end else if (load) begin
      lane  <= load_lane;
      be    <= '0;
      wdata <= '0;
    end else if (clear) begin
      lane  <= '0;
      be    <= '0;
      wdata <= '0;
    end else if (accept) begin
      wdata[8*lane +: 8] <= data;
      be[lane]           <= 1'b1;
      lane               <= lane + 1'b1;
    end
  end

  assign last_lane = (lane == LANE_BITS'(WORD_BYTES - 1));

endmodule

// File: rtl/mem_preload_engine.sv
// ---------------------------------------------------------------------------
// mem_preload_engine
// Streams a byte image from a byte source into main memory as word writes
// with byte enables, handling an unaligned start and a partial tail word.
// The CPU is held in reset until the whole image has been written.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle pulse, latches base_addr/byte_cnt
//                         (only honoured in IDLE/DONE/ERR)
//   base_addr, byte_cnt : first destination byte address, byte count
//   s_valid/s_data      : source byte stream
//   s_ready             : byte accepted when s_valid && s_ready
//   mem_req             : word write request, held until mem_ack
//   mem_addr            : word-aligned write address
//   mem_wdata, mem_be   : write data (lane i = byte at mem_addr+i), enables
//   mem_ack             : write accepted this cycle
//   busy                : filling or writing
//   done, err           : completion / range error levels, cleared by start
//   cpu_hold            : CPU reset hold, released when the image is resident
// ---------------------------------------------------------------------------
module mem_preload_engine
  import mem_preload_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int WORD_BYTES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [CNT_W-1:0]        byte_cnt,
  input  logic                    s_valid,
  input  logic [7:0]              s_data,
  output logic                    s_ready,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic [WORD_BYTES-1:0]   mem_be,
  input  logic                    mem_ack,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    cpu_hold
);

  localparam int LANE_BITS = lane_width(WORD_BYTES);

  state_t              state, state_next;
  logic [CNT_W-1:0]    remaining;
  logic [ADDR_W-1:0]   word_addr;
  logic                accept;
  logic                pk_load;
  logic                pk_clear;
  logic                last_lane;
  logic                rng_bad;
  logic                idle_like;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign accept    = (state == ST_FILL) && s_valid;
  assign rng_bad   = range_err({{(64-ADDR_W){1'b0}}, base_addr},
                               {{(64-CNT_W){1'b0}}, byte_cnt}, ADDR_W);

  // Next-state and datapath controls
  always_comb begin
    state_next = state;
    pk_load    = 1'b0;
    pk_clear   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          if (rng_bad) begin
            state_next = ST_ERR;
          end else if (byte_cnt == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_FILL;
            pk_load    = 1'b1;
          end
        end
      end
      ST_FILL: begin
        // Word is ready when its top lane fills or the image runs out.
        if (accept && (last_lane || (remaining == CNT_W'(1)))) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          if (remaining == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_FILL;
            pk_clear   = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, counters and status levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      word_addr <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      state    <= state_next;
      // Status tracks the state being entered so done and the release of
      // cpu_hold appear on the same edge as the DONE state.
      done     <= (state_next == ST_DONE);
      err      <= (state_next == ST_ERR);
      cpu_hold <= (state_next != ST_DONE);
      if (pk_load) begin
        remaining <= byte_cnt;
        word_addr <= {base_addr[ADDR_W-1:LANE_BITS], {LANE_BITS{1'b0}}};
      end else if (accept) begin
        remaining <= remaining - 1'b1;
      end
      if (pk_clear) begin
        word_addr <= word_addr + ADDR_W'(WORD_BYTES);
      end
    end
  end

  preload_word_packer #(
    .WORD_BYTES (WORD_BYTES),
    .LANE_BITS  (LANE_BITS)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pk_load),
    .load_lane (base_addr[LANE_BITS-1:0]),
    .clear     (pk_clear),
    .accept    (accept),
    .data      (s_data),
    .be        (mem_be),
    .wdata     (mem_wdata),
    .last_lane (last_lane)
  );

  assign s_ready  = (state == ST_FILL);
  assign mem_req  = (state == ST_WRITE);
  assign busy     = (state == ST_FILL) || (state == ST_WRITE);
  assign mem_addr = word_addr;

  // accept already implies idle_like is false; start outside idle_like
  // states has no path into the next-state logic.
  logic unused_ok;
  assign unused_ok = idle_like;

endmodule

// File: tb/tb_mem_preload_engine.sv
// ---------------------------------------------------------------------------
// tb_mem_preload_engine
// Directed bench for mem_preload_engine: drives byte images, services
// memory writes and compares each write and status level with
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_mem_preload_engine;

  localparam int ADDR_W = 15;
  localparam int WB     = 4;
  localparam int CNT_W  = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [CNT_W-1:0]    byte_cnt;
  logic                s_valid;
  logic [7:0]          s_data;
  logic                s_ready;
  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic [8*WB-1:0]     mem_wdata;
  logic [WB-1:0]       mem_be;
  logic                mem_ack;
  logic                busy;
  logic                done;
  logic                err;
  logic                cpu_hold;

  mem_preload_engine #(
    .ADDR_W     (ADDR_W),
    .WORD_BYTES (WB),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .byte_cnt  (byte_cnt),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_hold  (cpu_hold)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int wr_cnt = 0;

  always @(posedge clk) begin
    if (mem_req && mem_ack) wr_cnt <= wr_cnt + 1;
  end

  logic [7:0]        src_q[$];
  logic [ADDR_W-1:0] ea_q[$];
  logic [8*WB-1:0]   ed_q[$];
  logic [WB-1:0]     eb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    byte_cnt  = cnt;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic drive_src(input bit toggle);
    int idx = 0;
    int cyc = 0;
    while (idx < src_q.size() && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (toggle && (cyc % 2 == 1)) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = src_q[idx];
      end
      if (s_valid && s_ready) idx++;
    end
    if (idx < src_q.size()) chk("src_timeout", 64'(idx), 64'(src_q.size()));
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic sink(input int dly);
    int n = ea_q.size();
    for (int w = 0; w < n; w++) begin
      int t = 0;
      @(negedge clk);
      while (!mem_req && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!mem_req) begin
        chk("req_timeout", 64'(0), 64'(1));
        return;
      end
      chk("s_ready_in_write", 64'(s_ready), 64'(0));
      chk("addr",  64'(mem_addr),  64'(ea_q[w]));
      chk("wdata", 64'(mem_wdata), 64'(ed_q[w]));
      chk("be",    64'(mem_be),    64'(eb_q[w]));
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        chk("hold_req",   64'(mem_req),   64'(1));
        chk("hold_ready", 64'(s_ready),   64'(0));
        chk("hold_addr",  64'(mem_addr),  64'(ea_q[w]));
        chk("hold_wdata", 64'(mem_wdata), 64'(ed_q[w]));
        chk("hold_be",    64'(mem_be),    64'(eb_q[w]));
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("req_gap", 64'(mem_req), 64'(0));
    end
  endtask

  task automatic run_xfer(input string tag, input logic [ADDR_W-1:0] base,
                          input logic [CNT_W-1:0] cnt, input int dly,
                          input bit toggle, input bit poke);
    int w0   = wr_cnt;
    int nexp = ea_q.size();
    int t    = 0;
    pulse_start(base, cnt);
    chk({tag, "_ready"},    64'(s_ready),  64'(1));
    chk({tag, "_hold_on"},  64'(cpu_hold), 64'(1));
    chk({tag, "_busy"},     64'(busy),     64'(1));
    chk({tag, "_done_clr"}, 64'(done),     64'(0));
    fork
      drive_src(toggle);
      sink(dly);
      if (poke) begin
        repeat (3) @(negedge clk);
        start     = 1'b1;
        base_addr = 15'h0050;
        byte_cnt  = 16'd0;
        @(negedge clk);
        start     = 1'b0;
      end
    join
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"},     64'(done),         64'(1));
    chk({tag, "_hold_off"}, 64'(cpu_hold),     64'(0));
    chk({tag, "_idle"},     64'(busy),         64'(0));
    chk({tag, "_no_req"},   64'(mem_req),      64'(0));
    chk({tag, "_writes"},   64'(wr_cnt - w0),  64'(nexp));
    src_q.delete(); ea_q.delete(); ed_q.delete(); eb_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; byte_cnt = '0;
    s_valid = 1'b0; s_data = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(s_ready),   64'(0));
    chk("rst_req",   64'(mem_req),   64'(0));
    chk("rst_addr",  64'(mem_addr),  64'(0));
    chk("rst_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_be",    64'(mem_be),    64'(0));
    chk("rst_busy",  64'(busy),      64'(0));
    chk("rst_done",  64'(done),      64'(0));
    chk("rst_err",   64'(err),       64'(0));
    chk("rst_hold",  64'(cpu_hold),  64'(1));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", 64'(cpu_hold), 64'(1));

    // Aligned 8 bytes
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    ea_q  = '{15'h0100, 15'h0104};
    ed_q  = '{32'h44332211, 32'h88776655};
    eb_q  = '{4'hF, 4'hF};
    run_xfer("aligned", 15'h0100, 16'd8, 0, 1'b0, 1'b0);

    // Unaligned start and partial tail
    src_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    ea_q  = '{15'h0000, 15'h0004, 15'h0008};
    ed_q  = '{32'hA0000000, 32'hA4A3A2A1, 32'h000000A5};
    eb_q  = '{4'h8, 4'hF, 4'h1};
    run_xfer("unaligned", 15'h0003, 16'd6, 0, 1'b0, 1'b0);

    // Slow ack, gappy source
    src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    ea_q  = '{15'h0200, 15'h0204};
    ed_q  = '{32'h03020100, 32'h07060504};
    eb_q  = '{4'hE, 4'hF};
    run_xfer("slow", 15'h0201, 16'd7, 5, 1'b1, 1'b0);

    // Range error one byte past the top
    w0 = wr_cnt;
    pulse_start(15'h7FFE, 16'd3);
    chk("rng_err",  64'(err),      64'(1));
    chk("rng_done", 64'(done),     64'(0));
    chk("rng_hold", 64'(cpu_hold), 64'(1));
    chk("rng_busy", 64'(busy),     64'(0));
    repeat (3) @(negedge clk);
    chk("rng_no_req",    64'(mem_req),     64'(0));
    chk("rng_no_writes", 64'(wr_cnt - w0), 64'(0));

    // Full last word of memory
    src_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    ea_q  = '{15'h7FFC};
    ed_q  = '{32'hEFBEADDE};
    eb_q  = '{4'hF};
    run_xfer("top_word", 15'h7FFC, 16'd4, 0, 1'b0, 1'b0);
    chk("top_err_clr", 64'(err), 64'(0));

    // Image ending exactly at the top of memory is legal
    src_q = '{8'h31, 8'h32, 8'h33};
    ea_q  = '{15'h7FFC};
    ed_q  = '{32'h33323100};
    eb_q  = '{4'hE};
    run_xfer("top_edge", 15'h7FFD, 16'd3, 1, 1'b0, 1'b0);

    // Zero-length image
    w0 = wr_cnt;
    pulse_start(15'h0040, 16'd0);
    chk("zero_done", 64'(done),     64'(1));
    chk("zero_hold", 64'(cpu_hold), 64'(0));
    chk("zero_busy", 64'(busy),     64'(0));
    repeat (2) @(negedge clk);
    chk("zero_writes", 64'(wr_cnt - w0), 64'(0));

    // start while busy is ignored
    src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    ea_q  = '{15'h0010};
    ed_q  = '{32'h04030201};
    eb_q  = '{4'hF};
    run_xfer("busy_start", 15'h0010, 16'd4, 2, 1'b0, 1'b1);

    // Reset while a write is pending
    src_q = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
    pulse_start(15'h0020, 16'd4);
    drive_src(1'b0);
    chk("mid_req", 64'(mem_req), 64'(1));
    w0 = wr_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req",   64'(mem_req),   64'(0));
    chk("mid_rst_ready", 64'(s_ready),   64'(0));
    chk("mid_rst_addr",  64'(mem_addr),  64'(0));
    chk("mid_rst_wdata", 64'(mem_wdata), 64'(0));
    chk("mid_rst_be",    64'(mem_be),    64'(0));
    chk("mid_rst_busy",  64'(busy),      64'(0));
    chk("mid_rst_done",  64'(done),      64'(0));
    chk("mid_rst_hold",  64'(cpu_hold),  64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_req",    64'(mem_req),     64'(0));
    chk("post_rst_writes", 64'(wr_cnt - w0), 64'(0));
    chk("post_rst_hold",   64'(cpu_hold),    64'(1));
    src_q.delete();

    // Two-byte tail after recovery
    src_q = '{8'hC1, 8'hC2};
    ea_q  = '{15'h0300};
    ed_q  = '{32'h0000C2C1};
    eb_q  = '{4'h3};
    run_xfer("recover", 15'h0300, 16'd2, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
